// File: rtl/lcd_glyph_streamer.sv
// Streams a latched string of font codes to the LCD writer as OUT_W-bit beats, MSB first.
// Optional build macro LCD_STREAM_INVERT_EN adds a per-character invert_mask (highlight/cursor).
module lcd_glyph_streamer #(
    parameter  int NUM_CHARS  = 4,
    parameter  int CODE_W     = 6,
    parameter  int GLYPH_BITS = 256,
    parameter  int OUT_W      = 8,
    localparam int CHAR_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NUM_CHARS*CODE_W-1:0] codes,
    output logic                        busy,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef LCD_STREAM_INVERT_EN
    input  logic [NUM_CHARS-1:0]        invert_mask,
`endif
    output logic [CHAR_W-1:0]           out_char,
    output logic                        out_last,
    output logic                        done
);

    localparam int BEATS  = GLYPH_BITS / OUT_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(NUM_CHARS - 1);

    // Font codes: digits 0-9 occupy codes 0-9, letters A-P occupy codes 10-25.
    localparam logic [CODE_W-1:0] FONT_ZERO  = CODE_W'(0);
    localparam logic [CODE_W-1:0] FONT_ONE   = CODE_W'(1);
    localparam logic [CODE_W-1:0] FONT_TWO   = CODE_W'(2);
    localparam logic [CODE_W-1:0] FONT_THREE = CODE_W'(3);
    localparam logic [CODE_W-1:0] FONT_FOUR  = CODE_W'(4);
    localparam logic [CODE_W-1:0] FONT_FIVE  = CODE_W'(5);
    localparam logic [CODE_W-1:0] FONT_SIX   = CODE_W'(6);
    localparam logic [CODE_W-1:0] FONT_SEVEN = CODE_W'(7);
    localparam logic [CODE_W-1:0] FONT_EIGHT = CODE_W'(8);
    localparam logic [CODE_W-1:0] FONT_NINE  = CODE_W'(9);
    localparam logic [CODE_W-1:0] FONT_A     = CODE_W'(10);
    localparam logic [CODE_W-1:0] FONT_B     = CODE_W'(11);
    localparam logic [CODE_W-1:0] FONT_C     = CODE_W'(12);
    localparam logic [CODE_W-1:0] FONT_D     = CODE_W'(13);
    localparam logic [CODE_W-1:0] FONT_E     = CODE_W'(14);
    localparam logic [CODE_W-1:0] FONT_F     = CODE_W'(15);
    localparam logic [CODE_W-1:0] FONT_G     = CODE_W'(16);
    localparam logic [CODE_W-1:0] FONT_H     = CODE_W'(17);
    localparam logic [CODE_W-1:0] FONT_I     = CODE_W'(18);
    localparam logic [CODE_W-1:0] FONT_J     = CODE_W'(19);
    localparam logic [CODE_W-1:0] FONT_K     = CODE_W'(20);
    localparam logic [CODE_W-1:0] FONT_L     = CODE_W'(21);
    localparam logic [CODE_W-1:0] FONT_M     = CODE_W'(22);
    localparam logic [CODE_W-1:0] FONT_N     = CODE_W'(23);
    localparam logic [CODE_W-1:0] FONT_O     = CODE_W'(24);
    localparam logic [CODE_W-1:0] FONT_P     = CODE_W'(25);

    // Glyphs are stored as 8x8 sources (top row in the MSB byte) and doubled to 16x16 on lookup.
    localparam logic [63:0] LCD_0    = 64'h3C666E7666663C00;
    localparam logic [63:0] LCD_1    = 64'h1838181818187E00;
    localparam logic [63:0] LCD_2    = 64'h3C66060C30607E00;
    localparam logic [63:0] LCD_3    = 64'h3C66061C06663C00;
    localparam logic [63:0] LCD_4    = 64'h0C1C3C6C7E0C0C00;
    localparam logic [63:0] LCD_5    = 64'h7E607C0606663C00;
    localparam logic [63:0] LCD_6    = 64'h3C607C6666663C00;
    localparam logic [63:0] LCD_7    = 64'h7E060C1830303000;
    localparam logic [63:0] LCD_8    = 64'h3C66663C66663C00;
    localparam logic [63:0] LCD_9    = 64'h3C66663E060C3800;
    localparam logic [63:0] LCD_A    = 64'h183C66667E666600;
    localparam logic [63:0] LCD_B    = 64'h7C66667C66667C00;
    localparam logic [63:0] LCD_C    = 64'h3C66606060663C00;
    localparam logic [63:0] LCD_D    = 64'h786C6666666C7800;
    localparam logic [63:0] LCD_E    = 64'h7E60607860607E00;
    localparam logic [63:0] LCD_F    = 64'h7E60607860606000;
    localparam logic [63:0] LCD_G    = 64'h3C66606E66663C00;
    localparam logic [63:0] LCD_H    = 64'h6666667E66666600;
    localparam logic [63:0] LCD_I    = 64'h3C18181818183C00;
    localparam logic [63:0] LCD_J    = 64'h1E0C0C0C0C6C3800;
    localparam logic [63:0] LCD_K    = 64'h666C7870786C6600;
    localparam logic [63:0] LCD_L    = 64'h6060606060607E00;
    localparam logic [63:0] LCD_M    = 64'h63777F6B63636300;
    localparam logic [63:0] LCD_N    = 64'h66767E7E6E666600;
    localparam logic [63:0] LCD_O    = 64'h3C66666666663C00;
    localparam logic [63:0] LCD_P    = 64'h7C66667C60606000;
    localparam logic [63:0] LCD_NONE = 64'h0000000000000000;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t                      state;
    logic [NUM_CHARS*CODE_W-1:0] codes_q;
    logic [BEAT_W-1:0]           beat;
    logic [GLYPH_BITS-1:0]       shift_reg;
    logic [CODE_W-1:0]           cur_code;
    logic [GLYPH_BITS-1:0]       glyph;
`ifdef LCD_STREAM_INVERT_EN
    logic [NUM_CHARS-1:0]        mask_q;
`endif

    function automatic logic [63:0] font_source(input logic [CODE_W-1:0] code);
        case (code)
            FONT_ZERO:  font_source = LCD_0;
            FONT_ONE:   font_source = LCD_1;
            FONT_TWO:   font_source = LCD_2;
            FONT_THREE: font_source = LCD_3;
            FONT_FOUR:  font_source = LCD_4;
            FONT_FIVE:  font_source = LCD_5;
            FONT_SIX:   font_source = LCD_6;
            FONT_SEVEN: font_source = LCD_7;
            FONT_EIGHT: font_source = LCD_8;
            FONT_NINE:  font_source = LCD_9;
            FONT_A:     font_source = LCD_A;
            FONT_B:     font_source = LCD_B;
            FONT_C:     font_source = LCD_C;
            FONT_D:     font_source = LCD_D;
            FONT_E:     font_source = LCD_E;
            FONT_F:     font_source = LCD_F;
            FONT_G:     font_source = LCD_G;
            FONT_H:     font_source = LCD_H;
            FONT_I:     font_source = LCD_I;
            FONT_J:     font_source = LCD_J;
            FONT_K:     font_source = LCD_K;
            FONT_L:     font_source = LCD_L;
            FONT_M:     font_source = LCD_M;
            FONT_N:     font_source = LCD_N;
            FONT_O:     font_source = LCD_O;
            FONT_P:     font_source = LCD_P;
            default:    font_source = LCD_NONE;
        endcase
    endfunction

    function automatic logic [15:0] widen_row(input logic [7:0] b);
        widen_row = {b[7], b[7], b[6], b[6], b[5], b[5], b[4], b[4],
                     b[3], b[3], b[2], b[2], b[1], b[1], b[0], b[0]};
    endfunction

    // Each source row becomes two identical 16-pixel rows; row 0 ends up in the top bits.
    function automatic logic [255:0] scale_glyph(input logic [63:0] s);
        scale_glyph = {widen_row(s[63:56]), widen_row(s[63:56]),
                       widen_row(s[55:48]), widen_row(s[55:48]),
                       widen_row(s[47:40]), widen_row(s[47:40]),
                       widen_row(s[39:32]), widen_row(s[39:32]),
                       widen_row(s[31:24]), widen_row(s[31:24]),
                       widen_row(s[23:16]), widen_row(s[23:16]),
                       widen_row(s[15:8]),  widen_row(s[15:8]),
                       widen_row(s[7:0]),   widen_row(s[7:0])};
    endfunction

    always_comb begin
        cur_code = codes_q[out_char*CODE_W +: CODE_W];
        glyph    = scale_glyph(font_source(cur_code));
`ifdef LCD_STREAM_INVERT_EN
        if (mask_q[out_char]) begin
            glyph = ~glyph;
        end
`endif
    end

    assign out_data = shift_reg[GLYPH_BITS-1 -: OUT_W];

    // out_last is precomputed one beat ahead so it is a plain register at the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            codes_q   <= '0;
            beat      <= '0;
            shift_reg <= '0;
            out_char  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef LCD_STREAM_INVERT_EN
            mask_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        codes_q  <= codes;
`ifdef LCD_STREAM_INVERT_EN
                        mask_q   <= invert_mask;
`endif
                        out_char <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    shift_reg <= glyph;
                    beat      <= '0;
                    out_valid <= 1'b1;
                    out_last  <= (out_char == LAST_CHAR) && (BEATS == 1);
                    state     <= STREAM;
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        shift_reg <= shift_reg << OUT_W;
                        if (beat == LAST_BEAT) begin
                            beat      <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (out_char == LAST_CHAR) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                out_char <= out_char + 1'b1;
                                state    <= LOAD;
                            end
                        end else begin
                            beat     <= beat + 1'b1;
                            out_last <= (out_char == LAST_CHAR) && (beat + 1'b1 == LAST_BEAT);
                        end
                    end
                end
                DONE: begin
                    busy     <= 1'b0;
                    out_char <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_glyph_streamer.sv
// Self-checking bench for lcd_glyph_streamer: randomized strings and back-pressure against a pixel-level font model.
// Also exercises the per-character invert mask when built with LCD_STREAM_INVERT_EN.
module tb_lcd_glyph_streamer;

    localparam int NC      = 4;
    localparam int CW      = 6;
    localparam int GB      = 256;
    localparam int OW      = 8;
    localparam int BEATS   = GB / OW;
    localparam int MAX_CYC = 3000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [NC*CW-1:0] codes = '0;
    logic            busy;
    logic [OW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [1:0]      out_char;
    logic            out_last;
    logic            done;
    logic [NC-1:0]   mask_v = '0;
`ifdef LCD_STREAM_INVERT_EN
    logic [NC-1:0]   invert_mask = '0;
`endif

    logic            start1 = 1'b0;
    logic [CW-1:0]   codes1 = '0;
    logic            busy1;
    logic [15:0]     out_data1;
    logic            out_valid1;
    logic            out_ready1 = 1'b1;
    logic [0:0]      out_char1;
    logic            out_last1;
    logic            done1;

    int checks = 0;
    int passes = 0;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] obs_data[$];
    int            obs_char[$];
    bit            obs_last[$];
    int            done_cnt;
    int            done_cycle;
    int            stall_bad;
    bit            timed_out;

    always #5 clk = ~clk;

    lcd_glyph_streamer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .codes(codes), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef LCD_STREAM_INVERT_EN
        .invert_mask(invert_mask),
`endif
        .out_char(out_char), .out_last(out_last), .done(done)
    );

    lcd_glyph_streamer #(.NUM_CHARS(1), .OUT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .codes(codes1), .busy(busy1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
`ifdef LCD_STREAM_INVERT_EN
        .invert_mask(1'b0),
`endif
        .out_char(out_char1), .out_last(out_last1), .done(done1)
    );

    // 8x8 font sources (top row first); each pixel becomes a 2x2 block on the 16x16 LCD glyph.
    function automatic logic [63:0] font_rows(input int code);
        case (code)
            0:  return 64'h3C666E7666663C00;
            1:  return 64'h1838181818187E00;
            2:  return 64'h3C66060C30607E00;
            3:  return 64'h3C66061C06663C00;
            4:  return 64'h0C1C3C6C7E0C0C00;
            5:  return 64'h7E607C0606663C00;
            6:  return 64'h3C607C6666663C00;
            7:  return 64'h7E060C1830303000;
            8:  return 64'h3C66663C66663C00;
            9:  return 64'h3C66663E060C3800;
            10: return 64'h183C66667E666600;
            11: return 64'h7C66667C66667C00;
            12: return 64'h3C66606060663C00;
            13: return 64'h786C6666666C7800;
            14: return 64'h7E60607860607E00;
            15: return 64'h7E60607860606000;
            16: return 64'h3C66606E66663C00;
            17: return 64'h6666667E66666600;
            18: return 64'h3C18181818183C00;
            19: return 64'h1E0C0C0C0C6C3800;
            20: return 64'h666C7870786C6600;
            21: return 64'h6060606060607E00;
            22: return 64'h63777F6B63636300;
            23: return 64'h66767E7E6E666600;
            24: return 64'h3C66666666663C00;
            25: return 64'h7C66667C60606000;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [255:0] model_glyph(input int code, input bit inv);
        logic [63:0]  f;
        logic [255:0] g;
        f = font_rows(code);
        g = '0;
        for (int r = 0; r < 16; r++) begin
            logic [7:0]  b;
            logic [15:0] w;
            b = 8'(f >> (8 * (7 - r / 2)));
            w = '0;
            for (int c = 0; c < 8; c++) begin
                w = w << 2;
                if ((b & (8'h80 >> c)) != 8'h00) w = w | 16'h0003;
            end
            g = (g << 16) | 256'(w);
        end
        return inv ? ~g : g;
    endfunction

    task automatic build_expected(input logic [NC*CW-1:0] c, input logic [NC-1:0] m);
        exp_q.delete();
        for (int i = 0; i < NC; i++) begin
            logic [255:0] g;
            g = model_glyph(int'(c[i*CW +: CW]), m[i]);
            for (int k = 0; k < BEATS; k++) exp_q.push_back(OW'(g >> (GB - OW * (k + 1))));
        end
    endtask

    // Drives one start and records every accepted beat; ready_mode 0 = always ready, 1 = random.
    task automatic capture(input int ready_mode, input bit poke);
        int cyc;
        int end_cyc;
        bit prev_stall;
        logic [OW-1:0] prev_data;
        logic [1:0]    prev_char;
        logic          prev_last;
        obs_data.delete(); obs_char.delete(); obs_last.delete();
        done_cnt = 0; done_cycle = 0; stall_bad = 0; timed_out = 0;
        prev_stall = 0; prev_data = '0; prev_char = '0; prev_last = 1'b0;
        @(negedge clk);
        start = 1'b1;
        out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        cyc = 1;
        end_cyc = MAX_CYC;
        while (cyc <= end_cyc) begin
            if (done) begin
                done_cnt++;
                done_cycle = cyc;
                if (end_cyc == MAX_CYC) end_cyc = cyc + 6;
            end
            if (prev_stall && (!out_valid || out_data !== prev_data ||
                               out_char !== prev_char || out_last !== prev_last))
                stall_bad++;
            if (out_valid && out_ready) begin
                obs_data.push_back(out_data);
                obs_char.push_back(int'(out_char));
                obs_last.push_back(out_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data; prev_char = out_char; prev_last = out_last;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke && busy && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                codes = NC*CW'($urandom());
`ifdef LCD_STREAM_INVERT_EN
                invert_mask = NC'($urandom());
`endif
            end
            out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (done_cnt == 0) timed_out = 1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, out_valid, out_data, out_char, out_last, done} !== '0) begin
            $display("FAIL reset_outputs: got %h required 0", {busy, out_valid, out_data, out_char, out_last, done});
        end else passes++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL idle_without_start: busy=%b valid=%b required 0/0", busy, out_valid);
        end else passes++;
    endtask

    task automatic test_basic;
        logic [NC-1:0] m;
        codes = {6'd63, 6'd11, 6'd10, 6'd1};
        m = '0;
        mask_v = m;
`ifdef LCD_STREAM_INVERT_EN
        invert_mask = m;
`endif
        build_expected(codes, m);
        capture(0, 0);
        checks++;
        if (timed_out) $display("FAIL basic_timeout: no done within %0d cycles", MAX_CYC); else passes++;
        checks++;
        if (obs_data.size() != NC * BEATS) $display("FAIL basic_count: got %0d beats required %0d", obs_data.size(), NC * BEATS);
        else passes++;
        for (int k = 0; k < obs_data.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_data[k] !== exp_q[k]) $display("FAIL basic_beat%0d: got %h required %h", k, obs_data[k], exp_q[k]);
            else passes++;
            checks++;
            if (obs_char[k] != k / BEATS || obs_last[k] != (k == NC * BEATS - 1))
                $display("FAIL basic_side%0d: char=%0d last=%b required char=%0d last=%b",
                         k, obs_char[k], obs_last[k], k / BEATS, k == NC * BEATS - 1);
            else passes++;
        end
        if (obs_data.size() >= 2) begin
            checks++;
            if (obs_data[0] !== 8'h03 || obs_data[1] !== 8'hC0)
                $display("FAIL basic_first_row: got %h%h required 03c0", obs_data[0], obs_data[1]);
            else passes++;
        end
        checks++;
        if (done_cnt != 1 || done_cycle != NC * (BEATS + 1) + 2)
            $display("FAIL basic_done: count=%0d cycle=%0d required 1 at %0d", done_cnt, done_cycle, NC * (BEATS + 1) + 2);
        else passes++;
    endtask

    task automatic test_backpressure;
        build_expected(codes, mask_v);
        capture(1, 0);
        checks++;
        if (timed_out) $display("FAIL bp_timeout: no done within %0d cycles", MAX_CYC); else passes++;
        checks++;
        if (stall_bad != 0) $display("FAIL bp_stall_stable: got %0d unstable stalls required 0", stall_bad); else passes++;
        checks++;
        if (obs_data.size() != exp_q.size() || done_cnt != 1)
            $display("FAIL bp_count: beats=%0d done=%0d required %0d/1", obs_data.size(), done_cnt, exp_q.size());
        else passes++;
        for (int k = 0; k < obs_data.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_data[k] !== exp_q[k]) $display("FAIL bp_beat%0d: got %h required %h", k, obs_data[k], exp_q[k]);
            else passes++;
        end
    endtask

    task automatic test_restart_ignored;
        logic [NC*CW-1:0] orig;
        orig = {6'd25, 6'd26, 6'd0, 6'd9};
        codes = orig;
        build_expected(orig, mask_v);
        capture(1, 1);
        codes = orig;
`ifdef LCD_STREAM_INVERT_EN
        invert_mask = mask_v;
`endif
        checks++;
        if (obs_data.size() != NC * BEATS || done_cnt != 1)
            $display("FAIL restart_count: beats=%0d done=%0d required %0d/1", obs_data.size(), done_cnt, NC * BEATS);
        else passes++;
        for (int k = 0; k < obs_data.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_data[k] !== exp_q[k]) $display("FAIL restart_beat%0d: got %h required %h", k, obs_data[k], exp_q[k]);
            else passes++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL restart_idle: busy=%b required 0", busy); else passes++;
    endtask

    task automatic test_random_strings;
        for (int t = 0; t < 3; t++) begin
            codes = NC*CW'($urandom());
            codes[CW-1:0] = CW'($urandom_range(0, 27));
`ifdef LCD_STREAM_INVERT_EN
            mask_v = NC'($urandom());
            invert_mask = mask_v;
`endif
            build_expected(codes, mask_v);
            capture(t % 2, 0);
            checks++;
            if (obs_data.size() != exp_q.size() || done_cnt != 1 || stall_bad != 0)
                $display("FAIL rand%0d_shape: beats=%0d done=%0d stalls=%0d required %0d/1/0",
                         t, obs_data.size(), done_cnt, stall_bad, exp_q.size());
            else passes++;
            for (int k = 0; k < obs_data.size() && k < exp_q.size(); k++) begin
                checks++;
                if (obs_data[k] !== exp_q[k]) $display("FAIL rand%0d_beat%0d: got %h required %h", t, k, obs_data[k], exp_q[k]);
                else passes++;
            end
        end
        mask_v = '0;
`ifdef LCD_STREAM_INVERT_EN
        invert_mask = '0;
`endif
    endtask

    task automatic test_reset_midstream;
        int accepted;
        int n;
        bit hit;
        codes = {6'd63, 6'd11, 6'd10, 6'd1};
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        accepted = 0; n = 0; hit = 0;
        while (n < 500 && !hit) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_char == 2'd2 && accepted == 2 * BEATS + 10) hit = 1;
            else if (out_valid && out_ready) accepted++;
            n++;
        end
        checks++;
        if (!hit) $display("FAIL midreset_reach: char2 beat10 not reached, accepted=%0d", accepted); else passes++;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, out_data, out_char, out_last, done} !== '0)
            $display("FAIL midreset_outputs: got %h required 0", {busy, out_valid, out_data, out_char, out_last, done});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) $display("FAIL midreset_quiet: done=%b valid=%b required 0/0", done, out_valid);
        else passes++;
        build_expected(codes, mask_v);
        capture(0, 0);
        checks++;
        if (obs_data.size() != NC * BEATS || done_cycle != NC * (BEATS + 1) + 2)
            $display("FAIL midreset_restream: beats=%0d done_cycle=%0d required %0d/%0d",
                     obs_data.size(), done_cycle, NC * BEATS, NC * (BEATS + 1) + 2);
        else passes++;
        for (int k = 0; k < obs_data.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_data[k] !== exp_q[k]) $display("FAIL midreset_beat%0d: got %h required %h", k, obs_data[k], exp_q[k]);
            else passes++;
        end
    endtask

    task automatic test_single_char;
        logic [255:0] g;
        int beats;
        int n;
        bit saw_done;
        g = model_glyph(0, 1'b0);
        codes1 = 6'd0;
        @(negedge clk);
        start1 = 1'b1;
        out_ready1 = 1'b1;
        beats = 0; n = 0; saw_done = 0;
        while (n < 200 && !saw_done) begin
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            if (done1) saw_done = 1;
            if (out_valid1 && out_ready1) begin
                checks++;
                if (out_data1 !== 16'(g >> (GB - 16 * (beats + 1))) || out_char1 !== 1'b0 || out_last1 !== (beats == 15))
                    $display("FAIL single_beat%0d: data=%h char=%b last=%b required %h/0/%b",
                             beats, out_data1, out_char1, out_last1, 16'(g >> (GB - 16 * (beats + 1))), beats == 15);
                else passes++;
                beats++;
            end
            n++;
        end
        checks++;
        if (!saw_done || beats != 16) $display("FAIL single_count: beats=%0d done=%b required 16/1", beats, saw_done);
        else passes++;
    endtask

`ifdef LCD_STREAM_INVERT_EN
    task automatic test_invert;
        codes = {6'd63, 6'd11, 6'd10, 6'd1};
        mask_v = 4'b0010;
        invert_mask = mask_v;
        build_expected(codes, mask_v);
        capture(0, 0);
        checks++;
        if (obs_data.size() != NC * BEATS) $display("FAIL invert_count: got %0d required %0d", obs_data.size(), NC * BEATS);
        else passes++;
        for (int k = 0; k < obs_data.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_data[k] !== exp_q[k]) $display("FAIL invert_beat%0d: got %h required %h", k, obs_data[k], exp_q[k]);
            else passes++;
        end
        mask_v = '0;
        invert_mask = '0;
    endtask
`endif

    initial begin
        $display("[TB] lcd_glyph_streamer bench starting");
        test_reset();
        test_basic();
        test_backpressure();
        test_restart_ignored();
        test_random_strings();
        test_reset_midstream();
        test_single_char();
`ifdef LCD_STREAM_INVERT_EN
        test_invert();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
